serial_addsub_unit: RTL and testbench
=====================================

# serial_addsub_unit

Parametrised, multi-cycle adder/subtractor/accumulator that processes `DIGIT` bits per clock. It replaces the purely combinational add/subtract selection with a start/done handshake, a result register and an accumulate mode. It sits between the switch/key input logic and the hex-display translators. Its `S`/`COUT` outputs feed the display path and LEDs exactly as the combinational adders did, but are registered and held.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; must be ≥ 2.
- `DIGIT`, default 1: bits processed per cycle; must divide `WIDTH`. K = WIDTH/DIGIT is the run length in cycles.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `START`, in, 1: request an operation; sampled only in IDLE or DONE.
- `MODE`, in, 2: operation select.
  - 00 ADD: A+B.
  - 01 ADDC: A+B+CIN.
  - 10 SUB: A−B.
  - 11 ACC: S+A, with B ignored.
- `A`, in, WIDTH: operand A; latched on the accepting edge.
- `B`, in, WIDTH: operand B; latched on the accepting edge.
- `CIN`, in, 1: carry-in, used only in ADDC; latched on the accepting edge.
- `BUSY`, out, 1: high while digits are being processed.
- `DONE`, out, 1: one-cycle pulse when a new result is presented.
- `S`, out, WIDTH: registered result, held until the next DONE.
- `COUT`, out, 1: carry out of the MSB. In SUB it is the carry of A+~B+1, so 1 means no borrow.
- `OVF`, out, 1: two's-complement signed overflow of the result.
- `ZERO`, out, 1: combinational (S == 0).

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE: START=1 latches A, B, CIN and MODE, loads the carry register, clears the digit counter and moves to RUN.
  - RUN: each cycle adds one DIGIT-bit slice, LSB first, and shifts the sum into an internal shift register. The carry is kept in a 1-bit register. After K slices the state moves to DONE.
  - DONE: S, COUT and OVF update from the shift register and final carry, and DONE=1. START=1 in this state is accepted exactly as in IDLE and goes straight to RUN. Otherwise the state returns to IDLE.
- Initial carry is 0 for ADD, CIN for ADDC and 1 for SUB. In SUB the B operand is inverted at latch time.
- ACC mode uses the current S register as the second operand, snapshotted at the accepting edge. B is ignored.
- OVF = carry into MSB XOR carry out of MSB.
- START while in RUN is ignored, with no queuing. Changes to A, B, CIN or MODE during RUN have no effect.
- S, COUT and OVF change only in the cycle DONE asserts, or at reset.
- Reset values: state IDLE; BUSY=0, DONE=0, S=0, COUT=0, OVF=0, therefore ZERO=1. The accumulator is S, so reset clears it.
- Reset asserted mid-RUN aborts the operation immediately. No DONE pulse is issued and outputs return to their reset values.

## Timing
- Call the edge that accepts START "edge 0".
- BUSY is high from edge 0 through edge K, i.e. K cycles.
- After edge K the state is DONE: DONE=1 for exactly one cycle, BUSY=0 and the new result is visible.
- Latency from START acceptance to valid result is K cycles. Maximum throughput is one operation per K+1 cycles, by reasserting START during DONE.
- WIDTH=8, DIGIT=1 gives K=8. WIDTH=8, DIGIT=4 gives K=2.
- The counter wraps to 0 when entering DONE. The counter is log2(K) bits wide, minimum 1.

## Structure
- Shared package `addsub_pkg` holds:
  - mode constants `MODE_ADD`=2'b00, `MODE_ADDC`=2'b01, `MODE_SUB`=2'b10, `MODE_ACC`=2'b11;
  - FSM state encodings `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- One sub-module, `digit_adder`, is the natural split: a DIGIT-bit combinational ripple slice.
  - Inputs: x, y, carry in.
  - Outputs: sum, carry out, and carry into the top bit (needed for OVF on the final slice).

## Test plan
All cases use WIDTH=8, DIGIT=1 unless stated.
1. ADD, A=0x5A, B=0x3C → BUSY high for 8 cycles; S=0x96, COUT=0, OVF=1, DONE pulses once, 8 cycles after edge 0.
2. SUB, A=0x10, B=0x20 → S=0xF0, COUT=0 (borrow), OVF=0. SUB, A=0x80, B=0x01 → S=0x7F, COUT=1, OVF=1.
3. ADDC, A=0xFF, B=0x00, CIN=1 → S=0x00, COUT=1, ZERO=1, OVF=0.
4. From reset, three ACC operations with A=0x40, each started back-to-back by holding START during DONE:
   - S=0x40, then 0x80 with OVF=1, then 0xC0;
   - result spacing is exactly 9 cycles.
5. START pulsed and A/B changed at cycle 3 of RUN → ignored; the original result is produced and only one DONE pulse occurs.
6. RST_N low at cycle 4 of RUN → BUSY=0, S=0, ZERO=1 immediately, no DONE. Then, with DIGIT=4, ADD A=0x0F, B=0x01 → S=0x10 with K=2, so BUSY is high for 2 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants for the serial adder/subtractor: operation codes and FSM states.
package addsub_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_ADDC = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [1:0] MODE_ACC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple-carry slice. Also exposes the carry into the
// top bit so the caller can form signed overflow on the final slice.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic c;

  // Ripple the carry through the slice, LSB first.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would infer a latch.
    c     = ci;
    sum   = '0;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// Multi-cycle adder/subtractor/accumulator processing DIGIT bits per clock.
// START is accepted in IDLE or DONE; the result lands in S/COUT/OVF K cycles
// later together with a one-cycle DONE pulse. S doubles as the accumulator.
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  x_sh;
  logic [WIDTH-1:0]  y_sh;
  logic [WIDTH-1:0]  sum_sh;
  logic              carry;

  logic [DIGIT-1:0]  slice_sum;
  logic              slice_co;
  logic              slice_cmsb;
  logic [WIDTH-1:0]  sum_next;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x     (x_sh[DIGIT-1:0]),
    .y     (y_sh[DIGIT-1:0]),
    .ci    (carry),
    .sum   (slice_sum),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // New slice enters at the top; after K shifts the LSB slice sits at bit 0.
  assign sum_next = (sum_sh >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
  assign ZERO     = (S == '0);

  // Control FSM, operand/sum shift registers and registered result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the shift registers are reset along with the control state; they
      // are small flops, and a defined value keeps aborted runs from leaking.
      state  <= ST_IDLE;
      cnt    <= '0;
      x_sh   <= '0;
      y_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      S      <= '0;
      COUT   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      DONE <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            x_sh <= A;
            cnt  <= '0;
            BUSY <= 1'b1;
            state <= ST_RUN;
            case (MODE)
              MODE_ADD:  begin y_sh <= B;  carry <= 1'b0; end
              MODE_ADDC: begin y_sh <= B;  carry <= CIN;  end
              MODE_SUB:  begin y_sh <= ~B; carry <= 1'b1; end
              MODE_ACC:  begin y_sh <= S;  carry <= 1'b0; end
            endcase
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry  <= slice_co;
          sum_sh <= sum_next;
          x_sh   <= x_sh >> DIGIT;
          y_sh   <= y_sh >> DIGIT;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            S     <= sum_next;
            COUT  <= slice_co;
            OVF   <= slice_cmsb ^ slice_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: a WIDTH=8/DIGIT=1 instance checked
// by a decoupled monitor, plus a WIDTH=8/DIGIT=4 instance checked directly.
module tb_serial_addsub_unit;

  localparam int W  = 8;
  localparam int K1 = 8;
  localparam int K4 = 2;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start, cin, busy, done, cout, ovf, zero;
  logic [1:0]   mode;
  logic [W-1:0] a, b, s;

  logic         start4, cin4, busy4, done4, cout4, ovf4, zero4;
  logic [1:0]   mode4;
  logic [W-1:0] a4, b4, s4;

  serial_addsub_unit #(.WIDTH(W), .DIGIT(1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .A(a), .B(b), .CIN(cin),
    .BUSY(busy), .DONE(done), .S(s), .COUT(cout), .OVF(ovf), .ZERO(zero)
  );

  serial_addsub_unit #(.WIDTH(W), .DIGIT(4)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start4), .MODE(mode4), .A(a4), .B(b4), .CIN(cin4),
    .BUSY(busy4), .DONE(done4), .S(s4), .COUT(cout4), .OVF(ovf4), .ZERO(zero4)
  );

  exp_t         sb_q[$];
  int           done_cycles[$];
  int           checks = 0;
  int           errors = 0;
  int           cycle  = 0;
  logic [W-1:0] model_acc = '0;
  logic [W-1:0] model_acc4 = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic from the operation definitions.
  function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic [W-1:0] acc);
    exp_t r;
    int   u, sv;
    int   sx, sy, sacc;
    sx   = $signed(x);
    sy   = $signed(y);
    sacc = $signed(acc);
    case (md)
      2'b00: begin u = int'(x) + int'(y);                sv = sx + sy;               end
      2'b01: begin u = int'(x) + int'(y) + int'(ci);     sv = sx + sy + int'(ci);    end
      2'b10: begin u = int'(x) - int'(y) + (1 << W);     sv = sx - sy;               end
      default: begin u = int'(acc) + int'(x);            sv = sacc + sx;             end
    endcase
    r.s    = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    return r;
  endfunction

  task automatic push_op(input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    e = model(md, x, y, ci, model_acc);
    model_acc = e.s;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every DONE and checks timing and hold behaviour.
  int           busy_cnt = 0;
  logic [W-1:0] last_s = '0;
  exp_t         mon_e;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      busy_cnt = 0;
      last_s   = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cycles.push_back(cycle);
        check("busy_cycles", busy_cnt, K1);
        check("busy_low_at_done", busy, 1'b0);
        busy_cnt = 0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got DONE with S=%0h, required no DONE", s);
        end else begin
          mon_e = sb_q.pop_front();
          check("s", s, mon_e.s);
          check("cout", cout, mon_e.cout);
          check("ovf", ovf, mon_e.ovf);
          check("zero", zero, mon_e.s == '0);
        end
        last_s = s;
      end else begin
        check("s_hold", s, last_s);
      end
    end
  end

  task automatic wait_done(input string name);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no DONE within 40 cycles, required DONE", name);
  endtask

  task automatic run_op(input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    @(negedge clk);
    mode = md; a = x; b = y; cin = ci; start = 1'b1;
    push_op(md, x, y, ci);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("op");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    model_acc  = '0;
    model_acc4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op4(input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    int   bc;
    bit   seen;
    e = model(md, x, y, ci, model_acc4);
    model_acc4 = e.s;
    @(negedge clk);
    mode4 = md; a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    bc = 0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
      else if (busy4) bc++;
    end
    check("d4_done_seen", seen, 1'b1);
    check("d4_busy_cycles", bc, K4);
    check("d4_s", s4, e.s);
    check("d4_cout", cout4, e.cout);
    check("d4_ovf", ovf4, e.ovf);
    check("d4_zero", zero4, e.s == '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1);
  end

  initial begin
    start = 0; mode = 0; a = 0; b = 0; cin = 0;
    start4 = 0; mode4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_zero", zero, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed operations from the test plan.
    run_op(2'b00, 8'h5A, 8'h3C, 1'b0);
    run_op(2'b10, 8'h10, 8'h20, 1'b0);
    run_op(2'b10, 8'h80, 8'h01, 1'b0);
    run_op(2'b01, 8'hFF, 8'h00, 1'b1);

    // Three back-to-back accumulates from reset, START held through DONE.
    do_reset();
    done_cycles.delete();
    @(negedge clk);
    mode = 2'b11; a = 8'h40; b = 8'hA5; cin = 1'b0; start = 1'b1;
    push_op(2'b11, 8'h40, 8'hA5, 1'b0);
    push_op(2'b11, 8'h40, 8'hA5, 1'b0);
    push_op(2'b11, 8'h40, 8'hA5, 1'b0);
    wait_done("acc1");
    wait_done("acc2");
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("acc3");
    @(negedge clk);
    check("acc_done_count", done_cycles.size(), 3);
    if (done_cycles.size() == 3) begin
      check("acc_spacing_1", done_cycles[1] - done_cycles[0], K1 + 1);
      check("acc_spacing_2", done_cycles[2] - done_cycles[1], K1 + 1);
    end

    // START and operand changes during RUN are ignored.
    @(negedge clk);
    mode = 2'b00; a = 8'h21; b = 8'h12; cin = 1'b0; start = 1'b1;
    push_op(2'b00, 8'h21, 8'h12, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 a = 8'hFF; b = 8'hFF; mode = 2'b10; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignore_start");
    repeat (12) @(negedge clk);
    check("ignore_queue_empty", sb_q.size(), 0);

    // Randomised traffic.
    for (int i = 0; i < 25; i++)
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));

    // Reset in the middle of a run aborts it with no DONE.
    @(negedge clk);
    mode = 2'b00; a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_s", s, '0);
    check("abort_zero", zero, 1'b1);
    model_acc  = '0;
    model_acc4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Four-bit digit instance: K=2.
    run_op4(2'b00, 8'h0F, 8'h01, 1'b0);
    run_op4(2'b10, 8'h80, 8'h01, 1'b0);
    run_op4(2'b11, 8'h7F, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op4(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));

    repeat (2) @(negedge clk);
    check("final_queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
